register_access_master: RTL and testbench
=========================================

REGISTER_ACCESS_MASTER -- requirements
Module: register_access_master

Interface
REQ-001 Parameter RD_LATENCY, default 1, cycles from ch_rd_en to valid ch_rx_data; legal range 1..15.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 reset_n  in  1  synchronous reset, active-low.
REQ-004 cmd_valid  in  1  host command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_reg  in  32  target register number.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  host consumes response when rsp_valid && rsp_ready.
REQ-011 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-012 rsp_status  out  2  00 OK, 01 illegal register; 10 and 11 never driven.
REQ-013 ch_tx_data  out  32  data bus to channel register block (register number or write data).
REQ-014 ch_reg_num_le  out  1  register-number load strobe.
REQ-015 ch_wr_en  out  1  write strobe.
REQ-016 ch_rd_en  out  1  read strobe.
REQ-017 ch_rx_data  in  32  read-back data from channel.
REQ-018 ch_illegal_reg_num  in  1  channel flag: loaded register number out of range.
REQ-019 txn_count  out  16  completed responses, wraps.
REQ-020 err_count  out  16  illegal-status responses, saturates at 16'hFFFF.

Function
REQ-021 cmd_ready SHALL be 1 only in IDLE; cmd_write, cmd_reg and cmd_wdata SHALL be captured on acceptance.
REQ-022 States: IDLE, LOAD, CHECK, WRITE, READ, WAIT_RD, RESP.
REQ-023 All ch_* outputs SHALL be driven from flops; strobes SHALL be exactly one cycle wide; ch_tx_data SHALL be 0 outside LOAD and WRITE.
REQ-024 Cache: flops last_reg[31:0], last_illegal, cache_valid; a hit is cache_valid && captured cmd_reg == last_reg.
REQ-025 IDLE on acceptance: miss -> LOAD; hit with last_illegal=0 -> WRITE or READ per cmd_write; hit with last_illegal=1 -> RESP, status 01.
REQ-026 LOAD: ch_reg_num_le=1, ch_tx_data=cmd_reg; next CHECK.
REQ-027 CHECK: no strobe; at end of cycle sample ch_illegal_reg_num into last_illegal, set last_reg=cmd_reg, cache_valid=1; illegal -> RESP status 01, else WRITE or READ.
REQ-028 WRITE: ch_wr_en=1, ch_tx_data=cmd_wdata; next RESP, status 00, rdata 0.
REQ-029 READ: ch_rd_en=1; next WAIT_RD with counter loaded to RD_LATENCY.
REQ-030 WAIT_RD SHALL last exactly RD_LATENCY cycles; ch_rx_data SHALL be captured into rsp_rdata at end of the last one; next RESP, status 00.
REQ-031 RESP: rsp_valid=1; rsp_rdata and rsp_status held stable until handshake; on handshake -> IDLE, txn_count+1, err_count+1 (saturating) if status 01.
REQ-032 Miss write latency: acceptance edge to ch_wr_en = 3 cycles (LOAD, CHECK, WRITE); hit write: 1 cycle.
REQ-033 A new command SHALL NOT be accepted in the cycle of a response handshake; earliest acceptance is the following cycle.
REQ-034 Upper cmd_reg bits SHALL NOT be checked locally; legality comes solely from ch_illegal_reg_num.

Reset
REQ-035 reset_n=0 at a clock edge SHALL force IDLE, all strobes 0, ch_tx_data 0, rsp_valid 0, rsp_rdata 0, rsp_status 00, cache_valid 0, txn_count 0, err_count 0, regardless of state.
REQ-036 Reset mid-transaction SHALL discard the command and any pending response; cmd_ready SHALL be 1 in the first cycle after reset_n returns high.

Verification
REQ-037 Write miss: cmd_reg=5, wdata=32'hDEADBEEF -> le with tx=5, one idle cycle, wr_en with tx=DEADBEEF, rsp status 00, txn_count=1.
REQ-038 Read hit, RD_LATENCY=3: cmd_reg=5 read after REQ-037 -> no le, rd_en one cycle, capture 3 cycles later, rsp_rdata equals model value.
REQ-039 Illegal: cmd_reg=32'h40, channel flag=1 -> le only, no wr_en/rd_en, status 01, rdata 0, err_count+1; repeat -> no le, status 01 directly.
REQ-040 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_rdata, rsp_status stable, cmd_ready=0 throughout.
REQ-041 Reset during WAIT_RD -> no response, counters 0, next command to same register issues le (cache cleared).
REQ-042 err_count preloaded to 16'hFFFE via two-thousand-free stimulus (force) then three illegal responses -> err_count=16'hFFFF, txn_count keeps incrementing.

Source files
------------

// File: rtl/register_access_master.sv
// rtl/register_access_master.sv - host command/response master driving channel register strobes with a one-entry legality cache
module register_access_master #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_reg,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_status,
  output logic [31:0] ch_tx_data,
  output logic        ch_reg_num_le,
  output logic        ch_wr_en,
  output logic        ch_rd_en,
  input  logic [31:0] ch_rx_data,
  input  logic        ch_illegal_reg_num,
  output logic [15:0] txn_count,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, WRITE, READ, WAIT_RD, RESP} state_t;

  localparam logic [3:0] LAT = 4'(RD_LATENCY);
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ILLEGAL = 2'b01;

  state_t      state;
  logic        cap_write;
  logic [31:0] cap_reg;
  logic [31:0] cap_wdata;
  logic [31:0] last_reg;
  logic        last_illegal;
  logic        cache_valid;
  logic [3:0]  wait_cnt;
  logic        hit;

  // The cache compares against the register number presented at acceptance.
  assign hit = cache_valid && (cmd_reg == last_reg);

  // Control FSM; every output is a flop, strobes default low so each is exactly one cycle wide.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'h0;
      rsp_status    <= ST_OK;
      ch_tx_data    <= 32'h0;
      ch_reg_num_le <= 1'b0;
      ch_wr_en      <= 1'b0;
      ch_rd_en      <= 1'b0;
      cap_write     <= 1'b0;
      cap_reg       <= 32'h0;
      cap_wdata     <= 32'h0;
      last_reg      <= 32'h0;
      last_illegal  <= 1'b0;
      cache_valid   <= 1'b0;
      wait_cnt      <= 4'h0;
      txn_count     <= 16'h0;
      err_count     <= 16'h0;
    end else begin
      ch_reg_num_le <= 1'b0;
      ch_wr_en      <= 1'b0;
      ch_rd_en      <= 1'b0;
      ch_tx_data    <= 32'h0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            cap_write <= cmd_write;
            cap_reg   <= cmd_reg;
            cap_wdata <= cmd_wdata;
            if (!hit) begin
              state         <= LOAD;
              ch_reg_num_le <= 1'b1;
              ch_tx_data    <= cmd_reg;
            end else if (last_illegal) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_ILLEGAL;
              rsp_rdata  <= 32'h0;
            end else if (cmd_write) begin
              state      <= WRITE;
              ch_wr_en   <= 1'b1;
              ch_tx_data <= cmd_wdata;
            end else begin
              state    <= READ;
              ch_rd_en <= 1'b1;
            end
          end
        end
        LOAD: state <= CHECK;
        CHECK: begin
          // Channel has latched the register number; its legality flag is valid now.
          last_illegal <= ch_illegal_reg_num;
          last_reg     <= cap_reg;
          cache_valid  <= 1'b1;
          if (ch_illegal_reg_num) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_ILLEGAL;
            rsp_rdata  <= 32'h0;
          end else if (cap_write) begin
            state      <= WRITE;
            ch_wr_en   <= 1'b1;
            ch_tx_data <= cap_wdata;
          end else begin
            state    <= READ;
            ch_rd_en <= 1'b1;
          end
        end
        WRITE: begin
          state      <= RESP;
          rsp_valid  <= 1'b1;
          rsp_status <= ST_OK;
          rsp_rdata  <= 32'h0;
        end
        READ: begin
          state    <= WAIT_RD;
          wait_cnt <= LAT;
        end
        WAIT_RD: begin
          if (wait_cnt == 4'd1) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_OK;
            rsp_rdata  <= ch_rx_data;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            txn_count <= txn_count + 16'd1;
            if (rsp_status == ST_ILLEGAL && err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_access_master.sv
// tb/tb_register_access_master.sv - directed self-checking bench for register_access_master
module tb_register_access_master;

  localparam int RDL = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_reg = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [31:0] ch_tx_data;
  logic        ch_reg_num_le;
  logic        ch_wr_en;
  logic        ch_rd_en;
  logic [31:0] ch_rx_data;
  logic        ch_illegal_reg_num;
  logic [15:0] txn_count;
  logic [15:0] err_count;

  register_access_master #(.RD_LATENCY(RDL)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .ch_tx_data(ch_tx_data), .ch_reg_num_le(ch_reg_num_le), .ch_wr_en(ch_wr_en), .ch_rd_en(ch_rd_en),
    .ch_rx_data(ch_rx_data), .ch_illegal_reg_num(ch_illegal_reg_num),
    .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Channel model: 64 registers, numbers >= 64 are illegal, read data valid exactly RDL cycles after rd_en.
  logic [31:0] regs [0:63];
  logic [31:0] ch_latched = 32'h0;
  logic [31:0] rd_pipe [0:RDL-1];
  logic        init_done = 1'b0;

  assign ch_illegal_reg_num = (ch_latched >= 32'd64);
  assign ch_rx_data = rd_pipe[RDL-1];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) regs[i] <= 32'h1000_0000 + i;
      init_done <= 1'b1;
    end else if (ch_wr_en && ch_latched < 32'd64) begin
      regs[ch_latched[5:0]] <= ch_tx_data;
    end
    if (ch_reg_num_le) ch_latched <= ch_tx_data;
    rd_pipe[0] <= ch_rd_en ? regs[ch_latched[5:0]] : 32'hBAD0_BAD0;
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Strobe monitor, sampled on the falling edge.
  int cyc = 0;
  int le_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  int wr_cyc = 0, rd_cyc = 0;
  int wide_err = 0, tx_err = 0;
  logic [31:0] le_tx = 32'h0, wr_tx = 32'h0;
  logic prev_le = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ch_reg_num_le) begin le_cnt++; le_tx = ch_tx_data; end
    if (ch_wr_en) begin wr_cnt++; wr_tx = ch_tx_data; wr_cyc = cyc; end
    if (ch_rd_en) begin rd_cnt++; rd_cyc = cyc; end
    if ((ch_reg_num_le && prev_le) || (ch_wr_en && prev_wr) || (ch_rd_en && prev_rd)) wide_err++;
    if (!ch_reg_num_le && !ch_wr_en && ch_tx_data != 32'h0) tx_err++;
    prev_le = ch_reg_num_le;
    prev_wr = ch_wr_en;
    prev_rd = ch_rd_en;
  end

  // Issues one command; n is the cycle index just before the acceptance edge.
  task automatic do_cmd(input logic wr, input logic [31:0] rg, input logic [31:0] wd, input int hold,
                        output logic [31:0] rdata, output logic [1:0] st, output int n, output int rsp_cyc);
    int t;
    logic stable;
    rdata = 32'h0; st = 2'b11; n = 0; rsp_cyc = 0; stable = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_reg = rg; cmd_wdata = wd;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) check_eq("accept_timeout", 32'd0, 32'd1);
    n = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    if (!rsp_valid) begin
      check_eq("rsp_timeout", 32'd0, 32'd1);
    end else begin
      rsp_cyc = cyc; rdata = rsp_rdata; st = rsp_status;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_rdata !== rdata || rsp_status !== st || cmd_ready) stable = 1'b0;
      end
      if (hold > 0) check_eq("bp_stable", 32'(stable), 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("rsp_drop", 32'(rsp_valid), 32'd0);
    end
  endtask

  logic [31:0] rd;
  logic [1:0]  st;
  int n, rc, le0, wr0, rd0, t;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_strobes", {29'd0, ch_reg_num_le, ch_wr_en, ch_rd_en}, 32'd0);
    check_eq("rst_tx", ch_tx_data, 32'h0);
    check_eq("rst_counts", {txn_count, err_count}, 32'h0);
    check_eq("rst_status", {rsp_rdata[29:0], rsp_status}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write miss to register 5
    le0 = le_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
    do_cmd(1'b1, 32'd5, 32'hDEAD_BEEF, 0, rd, st, n, rc);
    check_eq("wmiss_le", 32'(le_cnt - le0), 32'd1);
    check_eq("wmiss_le_tx", le_tx, 32'd5);
    check_eq("wmiss_wr", 32'(wr_cnt - wr0), 32'd1);
    check_eq("wmiss_wr_tx", wr_tx, 32'hDEAD_BEEF);
    check_eq("wmiss_lat", 32'(wr_cyc - n), 32'd3);
    check_eq("wmiss_rd", 32'(rd_cnt - rd0), 32'd0);
    check_eq("wmiss_st", {rd[29:0], st}, 32'h0);
    check_eq("wmiss_txn", 32'(txn_count), 32'd1);
    check_eq("wmiss_model", regs[5], 32'hDEAD_BEEF);

    // Read hit to register 5
    le0 = le_cnt; rd0 = rd_cnt;
    do_cmd(1'b0, 32'd5, 32'h0, 0, rd, st, n, rc);
    check_eq("rhit_le", 32'(le_cnt - le0), 32'd0);
    check_eq("rhit_rd", 32'(rd_cnt - rd0), 32'd1);
    check_eq("rhit_rd_lat", 32'(rd_cyc - n), 32'd1);
    check_eq("rhit_rsp_lat", 32'(rc - n), 32'd5);
    check_eq("rhit_data", rd, 32'hDEAD_BEEF);
    check_eq("rhit_st", 32'(st), 32'd0);
    check_eq("rhit_txn", 32'(txn_count), 32'd2);

    // Read miss to register 7 (initial contents), then write hit and read back
    le0 = le_cnt;
    do_cmd(1'b0, 32'd7, 32'h0, 0, rd, st, n, rc);
    check_eq("rmiss_le", 32'(le_cnt - le0), 32'd1);
    check_eq("rmiss_rsp_lat", 32'(rc - n), 32'd7);
    check_eq("rmiss_data", rd, 32'h1000_0007);
    le0 = le_cnt;
    do_cmd(1'b1, 32'd7, 32'h1234_5678, 0, rd, st, n, rc);
    check_eq("whit_lat", 32'(wr_cyc - n), 32'd1);
    check_eq("whit_le", 32'(le_cnt - le0), 32'd0);
    do_cmd(1'b0, 32'd7, 32'h0, 0, rd, st, n, rc);
    check_eq("whit_readback", rd, 32'h1234_5678);

    // Illegal register, first via channel check, then straight from the cache
    le0 = le_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
    do_cmd(1'b1, 32'h40, 32'hAAAA_5555, 0, rd, st, n, rc);
    check_eq("ill_le", 32'(le_cnt - le0), 32'd1);
    check_eq("ill_strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
    check_eq("ill_st", 32'(st), 32'd1);
    check_eq("ill_rdata", rd, 32'h0);
    check_eq("ill_err", 32'(err_count), 32'd1);
    le0 = le_cnt;
    do_cmd(1'b0, 32'h40, 32'h0, 0, rd, st, n, rc);
    check_eq("ill2_le", 32'(le_cnt - le0), 32'd0);
    check_eq("ill2_strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
    check_eq("ill2_st", 32'(st), 32'd1);
    check_eq("ill2_lat", 32'(rc - n), 32'd1);
    check_eq("ill2_counts", {txn_count, err_count}, {16'd7, 16'd2});

    // Backpressure: response held for 10 cycles
    do_cmd(1'b0, 32'd5, 32'h0, 10, rd, st, n, rc);
    check_eq("bp_data", rd, 32'hDEAD_BEEF);
    check_eq("bp_txn", 32'(txn_count), 32'd8);

    // Reset while waiting for read data
    rd0 = rd_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_reg = 32'd5;
    t = 0;
    while (rd_cnt == rd0 && t < 20) begin @(negedge clk); t++; end
    cmd_valid = 1'b0;
    check_eq("rst_mid_rd_seen", 32'(rd_cnt - rd0), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check_eq("rst_mid_counts", {txn_count, err_count}, 32'h0);
    t = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) t++;
      @(negedge clk);
    end
    check_eq("rst_mid_no_rsp", 32'(t), 32'd0);
    check_eq("rst_mid_ready", 32'(cmd_ready), 32'd1);
    le0 = le_cnt;
    do_cmd(1'b0, 32'd5, 32'h0, 0, rd, st, n, rc);
    check_eq("rst_mid_le", 32'(le_cnt - le0), 32'd1);
    check_eq("rst_mid_data", rd, 32'hDEAD_BEEF);
    check_eq("rst_mid_txn", 32'(txn_count), 32'd1);

    // err_count saturation from a preloaded value
    @(negedge clk);
    force dut.err_count = 16'hFFFE;
    @(negedge clk);
    release dut.err_count;
    @(negedge clk);
    check_eq("sat_preload", 32'(err_count), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b1, 32'h40, 32'h0, 0, rd, st, n, rc);
      check_eq("sat_st", 32'(st), 32'd1);
      check_eq("sat_err", 32'(err_count), 32'h0000_FFFF);
      check_eq("sat_txn", 32'(txn_count), 32'(2 + i));
    end

    // Strobe width and data-bus idle checks over the whole run
    check_eq("strobe_width", 32'(wide_err), 32'd0);
    check_eq("tx_idle_zero", 32'(tx_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
